// File: rtl/cache_nway_pkg.sv
// cache_nway_pkg: shared cache types and line/word helpers.
package cache_nway_pkg;
    localparam int LINE_W = 128;

    typedef logic [LINE_W-1:0] lc3b_cache_line;
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} cache_state_t;

    function automatic logic [15:0] get_word(lc3b_cache_line l, logic [2:0] off);
        return l[{off, 4'd0} +: 16];
    endfunction

    function automatic lc3b_cache_line merge_word(lc3b_cache_line l, logic [2:0] off,
                                                  logic [1:0] be, logic [15:0] wd);
        lc3b_cache_line r;
        r = l;
        if (be[0]) r[{off, 4'd0} +: 8] = wd[7:0];
        if (be[1]) r[{off, 4'd8} +: 8] = wd[15:8];
        return r;
    endfunction
endpackage

// File: rtl/cache_nway_if.sv
// cache_nway_if: CPU-side and physical-memory-side buses of the cache.
interface cache_nway_if;
    import cache_nway_pkg::*;
    logic [15:0]    mem_address;
    logic           mem_read;
    logic           mem_write;
    logic [1:0]     mem_byte_enable;
    logic [15:0]    mem_wdata;
    logic [15:0]    mem_rdata;
    logic           mem_resp;
    logic [15:0]    pmem_address;
    logic           pmem_read;
    logic           pmem_write;
    lc3b_cache_line pmem_wdata;
    lc3b_cache_line pmem_rdata;
    logic           pmem_resp;

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );
    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface

// File: rtl/cache_nway_plru.sv
// plru_tree: tree pseudo-LRU victim select and post-access tree update.
// Node n has children 2n+1 (lower half) and 2n+2 (upper half); bit 1 steers the victim upward.
module plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         tree_i,
    input  logic [$clog2(WAYS)-1:0] way_i,
    output logic [$clog2(WAYS)-1:0] victim_o,
    output logic [WAYS-2:0]         tree_o
);
    localparam int L = $clog2(WAYS);

    logic [L-1:0] nv, na;

    always_comb begin
        tree_o   = tree_i;
        victim_o = '0;
        nv       = '0;
        na       = '0;
        for (int l = 0; l < L; l++) begin
            victim_o[L-1-l] = tree_i[nv];
            tree_o[na]      = ~way_i[L-1-l];
            nv              = L'(2 * nv + 1 + tree_i[nv]);
            na              = L'(2 * na + 1 + way_i[L-1-l]);
        end
    end
endmodule

// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative write-back/write-allocate cache with PLRU replacement,
// zero-wait hits, byte-masked writes and saturating hit/miss/writeback counters.
module cache_nway
    import cache_nway_pkg::*;
#(
    parameter int WAYS    = 4,
    parameter int SETS    = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    cache_nway_if.slave        bus,
    output logic [COUNT_W-1:0] hit_count,
    output logic [COUNT_W-1:0] miss_count,
    output logic [COUNT_W-1:0] wb_count
);
    localparam int WW = $clog2(WAYS);
    localparam int IW = $clog2(SETS);
    localparam int TW = 12 - IW;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [TW-1:0]     tag_q   [SETS][WAYS];
    lc3b_cache_line    data_q  [SETS][WAYS];
    logic [WAYS-2:0]   plru_q  [SETS];
    cache_state_t      state_q;
    logic              pmem_read_q, pmem_write_q;
    logic [WW-1:0]     victim_q;
    logic [COUNT_W-1:0] hit_q, miss_q, wb_q;

    logic [TW-1:0]   tag;
    logic [IW-1:0]   idx;
    logic [2:0]      off;
    logic            req, hit, inv, vic_dirty, unused;
    logic [WW-1:0]   hit_way, inv_way, plru_victim, victim_d;
    logic [WAYS-2:0] plru_d;

    assign tag    = bus.mem_address[15 -: TW];
    assign idx    = bus.mem_address[4 +: IW];
    assign off    = bus.mem_address[3:1];
    assign unused = bus.mem_address[0];
    assign req    = bus.mem_read | bus.mem_write;

    // Downward scan leaves the lowest matching / lowest invalid way selected.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        inv     = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[idx][w]) begin
                inv     = 1'b1;
                inv_way = WW'(w);
            end
        end
    end

    plru_tree #(.WAYS(WAYS)) u_plru (
        .tree_i  (plru_q[idx]),
        .way_i   (hit_way),
        .victim_o(plru_victim),
        .tree_o  (plru_d)
    );

    assign victim_d  = inv ? inv_way : plru_victim;
    assign vic_dirty = valid_q[idx][victim_d] && dirty_q[idx][victim_d];

    assign bus.mem_resp     = state_q == IDLE && req && hit;
    assign bus.mem_rdata    = get_word(data_q[idx][hit_way], off);
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = state_q == WRITEBACK ? {tag_q[idx][victim_q], idx, 4'h0} :
                              state_q == ALLOCATE  ? {tag, idx, 4'h0} : 16'h0;
    assign bus.pmem_wdata   = state_q == WRITEBACK ? data_q[idx][victim_q] : '0;
    assign hit_count        = hit_q;
    assign miss_count       = miss_q;
    assign wb_count         = wb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            victim_q     <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
            wb_q         <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && hit) begin
                        hit_q       <= hit_q + COUNT_W'(~&hit_q);
                        plru_q[idx] <= plru_d;
                        if (bus.mem_write && bus.mem_byte_enable != 2'b00) dirty_q[idx][hit_way] <= 1'b1;
                    end else if (req) begin
                        miss_q       <= miss_q + COUNT_W'(~&miss_q);
                        victim_q     <= victim_d;
                        state_q      <= vic_dirty ? WRITEBACK : ALLOCATE;
                        pmem_write_q <= vic_dirty;
                        pmem_read_q  <= !vic_dirty;
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        wb_q         <= wb_q + COUNT_W'(~&wb_q);
                        state_q      <= ALLOCATE;
                        pmem_write_q <= 1'b0;
                        pmem_read_q  <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (bus.pmem_resp) begin
                        state_q                  <= IDLE;
                        pmem_read_q              <= 1'b0;
                        valid_q[idx][victim_q]   <= 1'b1;
                        dirty_q[idx][victim_q]   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state_q == IDLE && req && hit && bus.mem_write)
            data_q[idx][hit_way] <= merge_word(data_q[idx][hit_way], off, bus.mem_byte_enable, bus.mem_wdata);
        if (!reset && state_q == ALLOCATE && bus.pmem_resp) begin
            data_q[idx][victim_q] <= bus.pmem_rdata;
            tag_q[idx][victim_q]  <= tag;
        end
    end
endmodule

// File: tb/tb_cache_nway.sv
// tb_cache_nway: directed scenarios plus random traffic against a set/way array model of the cache.
module tb_cache_nway;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] hit_count, miss_count, wb_count;
    int n_cmp = 0;
    int n_bad = 0;

    cache_nway_if bus();

    cache_nway #(.WAYS(4), .SETS(8), .COUNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .hit_count (hit_count),
        .miss_count(miss_count),
        .wb_count  (wb_count)
    );

    always #5 clk = ~clk;

    logic [127:0] pm [4096];

    // Model: per set/way valid, dirty, tag, line; 3-bit PLRU tree per set; phase 0 idle, 1 writeback, 2 fill.
    logic         mv [8][4];
    logic         md [8][4];
    logic [8:0]   mt [8][4];
    logic [127:0] ml [8][4];
    logic [2:0]   mp [8];
    int mh, mm, mw, ph, vw;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(int v);
        return v < 15 ? v + 1 : 15;
    endfunction

    // Way w is the victim when every node on its heap path points toward it.
    function automatic int pl_victim(logic [2:0] t);
        for (int w = 0; w < 4; w++) begin
            bit ok;
            ok = 1;
            for (int l = 0; l < 2; l++)
                if (int'(t[(1 << l) - 1 + (w >> (2 - l))]) != ((w >> (1 - l)) & 1)) ok = 0;
            if (ok) return w;
        end
        return 0;
    endfunction

    function automatic logic [2:0] pl_touch(logic [2:0] t, int w);
        for (int l = 0; l < 2; l++) t[(1 << l) - 1 + (w >> (2 - l))] = ((w >> (1 - l)) & 1) == 0;
        return t;
    endfunction

    initial begin : cmp
        logic req, wr;
        logic [15:0] a, exp_pa;
        logic [8:0] t;
        logic [127:0] ln;
        int s, off, hw;
        forever begin
            @(negedge clk);
            a   = bus.mem_address;
            s   = int'(a[6:4]);
            t   = a[15:7];
            off = int'(a[3:1]);
            req = bus.mem_read | bus.mem_write;
            wr  = bus.mem_write;
            hw  = -1;
            for (int w = 0; w < 4; w++) if (mv[s][w] === 1'b1 && mt[s][w] == t) hw = w;
            if (!reset) begin
                check("mem_resp", bus.mem_resp, ph == 0 && req && hw >= 0);
                if (ph == 0 && req && hw >= 0 && !wr) check("mem_rdata", bus.mem_rdata, ml[s][hw][off*16 +: 16]);
                check("pmem_write", bus.pmem_write, ph == 1);
                check("pmem_read", bus.pmem_read, ph == 2);
                exp_pa = ph == 1 ? {mt[s][vw], a[6:4], 4'h0} : ph == 2 ? {t, a[6:4], 4'h0} : 16'h0;
                check("pmem_address", bus.pmem_address, exp_pa);
                check("pmem_wdata", bus.pmem_wdata, ph == 1 ? ml[s][vw] : 128'h0);
                check("hit_count", hit_count, mh);
                check("miss_count", miss_count, mm);
                check("wb_count", wb_count, mw);
            end
            if (reset) begin
                ph = 0; mh = 0; mm = 0; mw = 0;
                for (int i = 0; i < 8; i++) begin
                    mp[i] = 3'b000;
                    for (int w = 0; w < 4; w++) begin mv[i][w] = 0; md[i][w] = 0; end
                end
            end else if (ph == 0 && req) begin
                if (hw >= 0) begin
                    if (wr) begin
                        ln = ml[s][hw];
                        if (bus.mem_byte_enable[0]) ln[off*16 +: 8] = bus.mem_wdata[7:0];
                        if (bus.mem_byte_enable[1]) ln[off*16+8 +: 8] = bus.mem_wdata[15:8];
                        ml[s][hw] = ln;
                        if (bus.mem_byte_enable != 2'b00) md[s][hw] = 1;
                    end
                    mp[s] = pl_touch(mp[s], hw);
                    mh = sat(mh);
                end else begin
                    mm = sat(mm);
                    vw = -1;
                    for (int w = 3; w >= 0; w--) if (!mv[s][w]) vw = w;
                    if (vw < 0) vw = pl_victim(mp[s]);
                    ph = (mv[s][vw] && md[s][vw]) ? 1 : 2;
                end
            end else if (ph == 1 && bus.pmem_resp) begin
                mw = sat(mw);
                ph = 2;
            end else if (ph == 2 && bus.pmem_resp) begin
                ml[s][vw] = pm[{t, a[6:4]}];
                mt[s][vw] = t;
                mv[s][vw] = 1;
                md[s][vw] = 0;
                ph = 0;
            end
        end
    end

    // Physical memory: responds in the third cycle a request is held.
    initial begin : pmem_model
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.pmem_resp) begin
                bus.pmem_resp = 1'b0;
                cnt = 0;
            end else if (!reset && (bus.pmem_read || bus.pmem_write)) begin
                cnt++;
                if (cnt == 3) begin
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_write) pm[bus.pmem_address[15:4]] = bus.pmem_wdata;
                    else bus.pmem_rdata = pm[bus.pmem_address[15:4]];
                end
            end else cnt = 0;
        end
    end

    logic saw_wb, saw_fill, wb_first;
    logic [15:0] wb_addr, fill_addr, rd;
    int waited;

    task automatic access(input logic [15:0] a, input logic r, input logic w, input logic [1:0] be,
                          input logic [15:0] wd, output logic [15:0] rdata, output int cyc);
        bus.mem_address = a; bus.mem_read = r; bus.mem_write = w;
        bus.mem_byte_enable = be; bus.mem_wdata = wd;
        cyc = 0; saw_wb = 0; saw_fill = 0; wb_first = 0;
        forever begin
            @(negedge clk);
            if (bus.pmem_write && !saw_wb) begin saw_wb = 1; wb_addr = bus.pmem_address; end
            if (bus.pmem_read && !saw_fill) begin saw_fill = 1; fill_addr = bus.pmem_address; wb_first = saw_wb; end
            if (bus.mem_resp) break;
            cyc++;
            if (cyc > 50) begin
                n_cmp++; n_bad++;
                $display("FAIL resp_timeout: no mem_resp after %0d cycles, required within 50", cyc);
                break;
            end
        end
        rdata = bus.mem_rdata;
        @(posedge clk);
        #1 bus.mem_read = 0; bus.mem_write = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int tot;
        for (int i = 0; i < 4096; i++) pm[i] = {$urandom, $urandom, $urandom, $urandom};
        pm[12'h004][31:16] = 16'h1234;
        bus.mem_address = 0; bus.mem_read = 0; bus.mem_write = 0;
        bus.mem_byte_enable = 0; bus.mem_wdata = 0;
        bus.pmem_resp = 0; bus.pmem_rdata = 0;
        check("plru_v000", pl_victim(3'b000), 0);
        check("plru_v101", pl_victim(3'b101), 3);
        check("plru_t0", pl_touch(3'b000, 0), 3'b011);
        check("plru_t3", pl_touch(3'b111, 3), 3'b010);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_pmem_read", bus.pmem_read, 0);
        check("rst_pmem_write", bus.pmem_write, 0);
        check("rst_mem_resp", bus.mem_resp, 0);
        check("rst_hit_count", hit_count, 0);
        @(posedge clk);
        #1;
        access(16'h0042, 1, 0, 2'b11, 0, rd, waited);
        check("t1_rdata", rd, 16'h1234);
        check("t1_miss_latency", waited, 4);
        check("t1_fill_addr", fill_addr, 16'h0040);
        check("t1_miss_count", miss_count, 1);
        check("t1_hit_count", hit_count, 1);
        access(16'h0042, 1, 0, 2'b11, 0, rd, waited);
        check("t1_hit_latency", waited, 0);
        check("t1_hit_count2", hit_count, 2);
        access(16'h0042, 0, 1, 2'b01, 16'hABCD, rd, waited);
        access(16'h0042, 1, 0, 2'b00, 0, rd, waited);
        check("t2_merge", rd, 16'h12CD);
        access(16'h0042, 0, 1, 2'b00, 16'hFFFF, rd, waited);
        access(16'h0042, 1, 0, 2'b00, 0, rd, waited);
        check("t2_be00", rd, 16'h12CD);
        access(16'h0000, 0, 1, 2'b11, 16'h7777, rd, waited);
        access(16'h0080, 1, 0, 2'b11, 0, rd, waited);
        access(16'h0100, 1, 0, 2'b11, 0, rd, waited);
        access(16'h0180, 1, 0, 2'b11, 0, rd, waited);
        access(16'h0200, 1, 0, 2'b11, 0, rd, waited);
        check("t3_saw_wb", saw_wb, 1);
        check("t3_wb_addr", wb_addr, 16'h0000);
        check("t3_wb_first", wb_first, 1);
        check("t3_fill_addr", fill_addr, 16'h0200);
        check("t3_wb_count", wb_count, 1);
        access(16'h0020, 0, 1, 2'b00, 16'h5555, rd, waited);
        access(16'h00A0, 1, 0, 2'b11, 0, rd, waited);
        access(16'h0120, 1, 0, 2'b11, 0, rd, waited);
        access(16'h01A0, 1, 0, 2'b11, 0, rd, waited);
        access(16'h0220, 1, 0, 2'b11, 0, rd, waited);
        check("t4_no_wb", saw_wb, 0);
        check("t4_fill_addr", fill_addr, 16'h0220);
        check("t4_wb_count", wb_count, 1);
        access(16'h0030, 0, 1, 2'b11, 16'hBEEF, rd, waited);
        access(16'h00B0, 1, 0, 2'b11, 0, rd, waited);
        access(16'h0130, 1, 0, 2'b11, 0, rd, waited);
        access(16'h01B0, 1, 0, 2'b11, 0, rd, waited);
        bus.mem_address = 16'h0230; bus.mem_read = 1;
        waited = 0;
        while (!bus.pmem_write && waited < 20) begin
            @(posedge clk);
            #1 waited++;
        end
        check("t5_wb_started", bus.pmem_write, 1);
        @(posedge clk);
        #1 reset = 1; bus.mem_read = 0;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("t5_abort_pmem_write", bus.pmem_write, 0);
        check("t5_abort_pmem_read", bus.pmem_read, 0);
        check("t5_miss_cleared", miss_count, 0);
        @(posedge clk);
        #1;
        access(16'h0000, 1, 0, 2'b11, 0, rd, waited);
        check("t5_remiss_latency", waited, 4);
        check("t5_miss_count", miss_count, 1);
        tot = 0;
        for (int i = 0; i < 20; i++) begin
            access(16'h0000, 1, 0, 2'b11, 0, rd, waited);
            tot += waited;
        end
        check("t6_hit_waits", tot, 0);
        check("t6_hit_sat", hit_count, 15);
        access(16'h0000, 1, 1, 2'b11, 16'h5A5A, rd, waited);
        access(16'h0000, 1, 0, 2'b11, 0, rd, waited);
        check("t6_rw_is_write", rd, 16'h5A5A);
        for (int i = 0; i < 400; i++) begin
            int op;
            op = int'($urandom_range(0, 2));
            access({6'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 4'($urandom)},
                   op != 1, op != 0, 2'($urandom), 16'($urandom), rd, waited);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
